// File: rtl/fft_pair_buf.sv
// rtl/fft_pair_buf.sv - FFT butterfly operand pairing buffer with block framing and flush
// Holds the first DEPTH valid beats of each 2*DEPTH block in a pointer-addressed
// buffer. Each later beat is presented together with the beat DEPTH valid beats
// earlier as one butterfly operand pair.
module fft_pair_buf #(
   parameter int DATA_WIDTH = 9,
   parameter int LANES      = 16,
   parameter int DEPTH      = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         din_valid,
   input  logic                         flush,
   input  logic signed [DATA_WIDTH-1:0] din_i    [0:LANES-1],
   input  logic signed [DATA_WIDTH-1:0] din_q    [0:LANES-1],
   output logic signed [DATA_WIDTH-1:0] dout_a_i [0:LANES-1],
   output logic signed [DATA_WIDTH-1:0] dout_a_q [0:LANES-1],
   output logic signed [DATA_WIDTH-1:0] dout_b_i [0:LANES-1],
   output logic signed [DATA_WIDTH-1:0] dout_b_q [0:LANES-1],
   output logic                         bufly_enable,
   output logic                         block_done
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW = $clog2(2 * DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [HW-1:0] PH_HALF  = HW'(DEPTH);
   localparam logic [HW-1:0] PH_LAST  = HW'(2 * DEPTH - 1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [HW-1:0] phase_q, phase_d;
   logic          bufly_q, bufly_d;
   logic          done_q, done_d;
   logic          mem_we;
   logic          pair_ld;

   logic signed [DATA_WIDTH-1:0] mem_i_q [0:DEPTH-1][0:LANES-1];
   logic signed [DATA_WIDTH-1:0] mem_q_q [0:DEPTH-1][0:LANES-1];
   logic signed [DATA_WIDTH-1:0] a_i_q   [0:LANES-1];
   logic signed [DATA_WIDTH-1:0] a_q_q   [0:LANES-1];
   logic signed [DATA_WIDTH-1:0] b_i_q   [0:LANES-1];
   logic signed [DATA_WIDTH-1:0] b_q_q   [0:LANES-1];

   // Framing: pointer and phase step only on accepted beats; flush drops the beat
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      phase_d  = phase_q;
      bufly_d  = 1'b0;
      done_d   = 1'b0;
      mem_we   = 1'b0;
      pair_ld  = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         phase_d  = '0;
      end else if (din_valid) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
         phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + HW'(1);
         if (phase_q < PH_HALF) begin
            mem_we = 1'b1;
         end else begin
            pair_ld = 1'b1;
            bufly_d = 1'b1;
            done_d  = (phase_q == PH_LAST);
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         phase_q  <= '0;
         bufly_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         phase_q  <= phase_d;
         bufly_q  <= bufly_d;
         done_q   <= done_d;
      end
   end

   // First-half beats land in the buffer; second half only reads it
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int d = 0; d < DEPTH; d++) begin
            for (int l = 0; l < LANES; l++) begin
               mem_i_q[d][l] <= '0;
               mem_q_q[d][l] <= '0;
            end
         end
      end else if (mem_we) begin
         for (int l = 0; l < LANES; l++) begin
            mem_i_q[wr_ptr_q][l] <= din_i[l];
            mem_q_q[wr_ptr_q][l] <= din_q[l];
         end
      end
   end

   // Operand pair registers: stored beat as A, current beat as B, held otherwise
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         for (int l = 0; l < LANES; l++) begin
            a_i_q[l] <= '0;
            a_q_q[l] <= '0;
            b_i_q[l] <= '0;
            b_q_q[l] <= '0;
         end
      end else if (pair_ld) begin
         for (int l = 0; l < LANES; l++) begin
            a_i_q[l] <= mem_i_q[wr_ptr_q][l];
            a_q_q[l] <= mem_q_q[wr_ptr_q][l];
            b_i_q[l] <= din_i[l];
            b_q_q[l] <= din_q[l];
         end
      end
   end

   assign dout_a_i     = a_i_q;
   assign dout_a_q     = a_q_q;
   assign dout_b_i     = b_i_q;
   assign dout_b_q     = b_q_q;
   assign bufly_enable = bufly_q;
   assign block_done   = done_q;

endmodule

// File: tb/tb_fft_pair_buf.sv
// tb/tb_fft_pair_buf.sv - self-checking bench for fft_pair_buf
module tb_fft_pair_buf;

   localparam int W = 9;
   localparam int L = 2;
   localparam int D = 4;

   logic clk;
   logic rstn;
   logic din_valid;
   logic flush;
   logic signed [W-1:0] din_i    [0:L-1];
   logic signed [W-1:0] din_q    [0:L-1];
   logic signed [W-1:0] dout_a_i [0:L-1];
   logic signed [W-1:0] dout_a_q [0:L-1];
   logic signed [W-1:0] dout_b_i [0:L-1];
   logic signed [W-1:0] dout_b_q [0:L-1];
   logic bufly_enable;
   logic block_done;

   fft_pair_buf #(.DATA_WIDTH(W), .LANES(L), .DEPTH(D)) dut (
      .clk(clk), .rstn(rstn), .din_valid(din_valid), .flush(flush),
      .din_i(din_i), .din_q(din_q),
      .dout_a_i(dout_a_i), .dout_a_q(dout_a_q),
      .dout_b_i(dout_b_i), .dout_b_q(dout_b_q),
      .bufly_enable(bufly_enable), .block_done(block_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Beat packing: [8:0]=lane0 I, [17:9]=lane0 Q, [26:18]=lane1 I, [35:27]=lane1 Q
   typedef struct packed {
      logic        r;
      logic        f;
      logic        v;
      logic [35:0] din;
      logic        en;
      logic        dn;
      logic [35:0] a;
      logic [35:0] b;
   } vec_t;

   vec_t tv[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [35:0] Z  = 36'd0;
   localparam logic [35:0] EV = {9'h0FF, 9'h100, 9'h0FF, 9'h100};
   localparam logic [35:0] OD = {9'h100, 9'h0FF, 9'h100, 9'h0FF};

   function automatic logic [35:0] pat(input int k);
      return {9'(20 + k), 9'(10 + k), 9'(-k), 9'(k)};
   endfunction

   function automatic logic [35:0] ext(input int j);
      return (j % 2 == 0) ? EV : OD;
   endfunction

   task automatic add(input logic r, input logic f, input logic v, input logic [35:0] d,
                      input logic en, input logic dn, input logic [35:0] a, input logic [35:0] b);
      vec_t t;
      t.r = r; t.f = f; t.v = v; t.din = d; t.en = en; t.dn = dn; t.a = a; t.b = b;
      tv.push_back(t);
   endtask

   task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic f, input logic v, input logic [35:0] d,
                        input bit glitch);
      @(negedge clk);
      rstn = r; flush = f; din_valid = v;
      din_i[0] = d[8:0]; din_q[0] = d[17:9]; din_i[1] = d[26:18]; din_q[1] = d[35:27];
      if (glitch) begin
         #1 rstn = 1'b0;
         #1 rstn = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] got_a();
      return {dout_a_q[1], dout_a_i[1], dout_a_q[0], dout_a_i[0]};
   endfunction

   function automatic logic [35:0] got_b();
      return {dout_b_q[1], dout_b_i[1], dout_b_q[0], dout_b_i[0]};
   endfunction

   // Reference model: beats of the current block in arrival order
   logic [35:0] blk[$];
   logic        m_en, m_dn;
   logic [35:0] m_a, m_b;

   task automatic cycle(input logic r, input logic f, input logic v, input logic [35:0] d,
                        input bit glitch, input string tag);
      if (!r || f) begin
         blk.delete();
         m_en = 0; m_dn = 0; m_a = Z; m_b = Z;
      end else if (v) begin
         blk.push_back(d);
         if (blk.size() > D) begin
            m_a  = blk[blk.size() - 1 - D];
            m_b  = d;
            m_en = 1;
            m_dn = (blk.size() == 2 * D);
            if (m_dn) blk.delete();
         end else begin
            m_en = 0; m_dn = 0;
         end
      end else begin
         m_en = 0; m_dn = 0;
      end
      apply(r, f, v, d, glitch);
      chk({tag, "_en"}, 36'(bufly_enable), 36'(m_en));
      chk({tag, "_done"}, 36'(block_done), 36'(m_dn));
      chk({tag, "_a"}, got_a(), m_a);
      chk({tag, "_b"}, got_b(), m_b);
   endtask

   initial begin
      logic [35:0] ha, hb;
      logic [13:0] gp;
      logic [63:0] rr;
      int k;
      rstn = 1'b1; flush = 1'b0; din_valid = 1'b0;
      for (int l = 0; l < L; l++) begin
         din_i[l] = '0; din_q[l] = '0;
      end

      // Reset held with valid beats present
      for (int j = 0; j < 3; j++) add(0, 0, 1, pat(77), 0, 0, Z, Z);
      // Continuous block
      for (int j = 0; j < 8; j++)
         add(1, 0, 1, pat(j), j >= 4, j == 7, (j >= 4) ? pat(j - 4) : Z, (j >= 4) ? pat(j) : Z);
      // Gapped block
      gp = 14'b10101101011001;
      ha = pat(3); hb = pat(7); k = 0;
      for (int i = 0; i < 14; i++) begin
         if (gp[i]) begin
            if (k >= 4) begin ha = pat(k - 4); hb = pat(k); end
            add(1, 0, 1, pat(k), k >= 4, k == 7, ha, hb);
            k++;
         end else begin
            add(1, 0, 0, pat(99), 0, 0, ha, hb);
         end
      end
      // Flush after 5 beats, then a clean block
      for (int j = 0; j < 4; j++) add(1, 0, 1, pat(30 + j), 0, 0, pat(3), pat(7));
      add(1, 0, 1, pat(34), 1, 0, pat(30), pat(34));
      add(1, 1, 1, pat(35), 0, 0, Z, Z);
      for (int j = 0; j < 8; j++)
         add(1, 0, 1, pat(100 + j), j >= 4, j == 7, (j >= 4) ? pat(96 + j) : Z, (j >= 4) ? pat(100 + j) : Z);
      // Extremes over two chained blocks
      ha = pat(103); hb = pat(107);
      for (int j = 0; j < 16; j++) begin
         if (j % 8 >= 4) begin ha = ext(j - 4); hb = ext(j); end
         add(1, 0, 1, ext(j), j % 8 >= 4, j % 8 == 7, ha, hb);
      end
      // Reset mid-block
      for (int j = 0; j < 4; j++) add(1, 0, 1, pat(60 + j), 0, 0, OD, OD);
      add(1, 0, 1, pat(64), 1, 0, pat(60), pat(64));
      add(1, 0, 1, pat(65), 1, 0, pat(61), pat(65));
      add(0, 0, 1, pat(66), 0, 0, Z, Z);
      for (int j = 0; j < 8; j++)
         add(1, 0, 1, pat(50 + j), j >= 4, j == 7, (j >= 4) ? pat(46 + j) : Z, (j >= 4) ? pat(50 + j) : Z);

      foreach (tv[i]) begin
         apply(tv[i].r, tv[i].f, tv[i].v, tv[i].din, 1'b0);
         chk($sformatf("vec%0d_en", i), 36'(bufly_enable), 36'(tv[i].en));
         chk($sformatf("vec%0d_done", i), 36'(block_done), 36'(tv[i].dn));
         chk($sformatf("vec%0d_a", i), got_a(), tv[i].a);
         chk($sformatf("vec%0d_b", i), got_b(), tv[i].b);
      end

      // Reset glitch between edges in the middle of a block must be ignored
      cycle(0, 0, 0, Z, 0, "glr");
      for (int j = 0; j < 8; j++) cycle(1, 0, 1, pat(40 + j), j == 2 || j == 5, "gl");

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rr = {$urandom, $urandom};
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 3) != 0), rr[35:0], 0, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
